// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-adder cell and a carry
// flip-flop. Operands are captured on an accepted start, added LSB-first over
// WIDTH cycles, and the result is presented with a one-cycle done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_sum_c;
  logic               fa_carry_c;
  logic               last_bit_c;

  // Single full-adder cell working on the current LSBs and the stored carry.
  always_comb begin
    fa_sum_c   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE waits for start, RUN lasts WIDTH cycles, DONE one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start)      state_d = S_RUN;
      S_RUN:  if (last_bit_c) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Datapath next values; everything holds unless the state says otherwise.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;

    unique case (state_q)
      S_IDLE: begin
        // Start is only honoured here, so operands cannot be disturbed mid-run.
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        // Result enters from the MSB side so bit 0 lands at the LSB after WIDTH shifts.
        sum_d   = {fa_sum_c, sum_q[WIDTH-1:1]};
        carry_d = fa_carry_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (last_bit_c) begin
          cout_d = fa_carry_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Result and carry simply hold through DONE and into IDLE.
      end
      default: begin
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Datapath and status registers; reset clears all visible results.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed scenarios plus random
// operands checked against a plain-arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W       = 8;
  localparam int          EXP_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the full-width arithmetic sum.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Drive one operation from the current (IDLE) cycle, scramble the inputs
  // afterwards, and return observations up to the IDLE cycle after done.
  task automatic run_op(input  logic [W-1:0] xa, input logic [W-1:0] xb,
                        output int lat, output logic [W-1:0] rs, output logic rc,
                        output int busy_bad, output logic done_after,
                        output logic busy_after, output logic [W-1:0] sum_after,
                        output logic cout_after);
    lat      = 0;
    rs       = '0;
    rc       = 1'b0;
    busy_bad = 0;
    a = xa;
    b = xb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int k = 1; k <= 20; k++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = k;
        rs  = sum;
        rc  = cout;
        break;
      end
      tick();
    end
    tick();
    done_after = done;
    busy_after = busy;
    sum_after  = sum;
    cout_after = cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat, bb; logic [W-1:0] rs, sa; logic rc, da, ba, ca;
    run_op(8'h35, 8'h4A, lat, rs, rc, bb, da, ba, sa, ca);
    total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, EXP_LAT); end
    total++; if (rs !== 8'h7F) begin bad++; $display("FAIL basic_sum got=%h want=7f", rs); end
    total++; if (rc !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", rc); end
    total++; if (bb !== 0) begin bad++; $display("FAIL basic_busy low_cycles=%0d want=0", bb); end
    total++; if (ba !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", ba); end
    total++; if (sa !== 8'h7F) begin bad++; $display("FAIL basic_sum_hold got=%h want=7f", sa); end
  endtask

  task automatic test_overflow();
    int lat, bb; logic [W-1:0] rs, sa; logic rc, da, ba, ca;
    run_op(8'hFF, 8'h01, lat, rs, rc, bb, da, ba, sa, ca);
    total++; if (rs !== 8'h00) begin bad++; $display("FAIL ovf_sum got=%h want=00", rs); end
    total++; if (rc !== 1'b1) begin bad++; $display("FAIL ovf_cout got=%b want=1", rc); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL ovf_done_one_cycle got=%b want=0", da); end
    total++; if (ca !== 1'b1) begin bad++; $display("FAIL ovf_cout_hold got=%b want=1", ca); end
    total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", lat, EXP_LAT); end
  endtask

  // Second start lands in the IDLE cycle right after DONE: done at T+9 and T+19.
  task automatic test_back_to_back();
    int lat1, lat2, bb1, bb2; logic [W-1:0] rs1, rs2, sa; logic rc1, rc2, da, ba, ca;
    run_op(8'hFF, 8'hFF, lat1, rs1, rc1, bb1, da, ba, sa, ca);
    run_op(8'h00, 8'h00, lat2, rs2, rc2, bb2, da, ba, sa, ca);
    total++; if (lat1 !== EXP_LAT) begin bad++; $display("FAIL b2b_lat1 got=%0d want=%0d", lat1, EXP_LAT); end
    total++; if (rs1 !== 8'hFE || rc1 !== 1'b1) begin bad++; $display("FAIL b2b_res1 got=%b_%h want=1_fe", rc1, rs1); end
    total++; if (lat2 !== EXP_LAT) begin bad++; $display("FAIL b2b_lat2 got=%0d want=%0d", lat2, EXP_LAT); end
    total++; if (rs2 !== 8'h00 || rc2 !== 1'b0) begin bad++; $display("FAIL b2b_res2 got=%b_%h want=0_00", rc2, rs2); end
    total++; if (bb2 !== 0) begin bad++; $display("FAIL b2b_busy2 low_cycles=%0d want=0", bb2); end
  endtask

  task automatic test_start_ignored();
    int lat = 0;
    int bb = 0;
    logic [W-1:0] rs = '0;
    a = 8'h35;
    b = 8'h4A;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy !== 1'b1) bb++;
      if (done === 1'b1) begin lat = k; rs = sum; break; end
      if (k == 3) begin start = 1'b1; a = 8'h11; b = 8'h11; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    total++; if (lat !== EXP_LAT) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, EXP_LAT); end
    total++; if (rs !== 8'h7F) begin bad++; $display("FAIL ign_sum got=%h want=7f", rs); end
    total++; if (bb !== 0) begin bad++; $display("FAIL ign_busy low_cycles=%0d want=0", bb); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_reset_abort();
    int dseen = 0;
    int lat, bb; logic [W-1:0] rs, sa; logic rc, da, ba, ca;
    a = 8'h35;
    b = 8'h4A;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum got=%h want=00", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b want=0", cout); end
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) dseen++;
      tick();
    end
    total++; if (dseen !== 0) begin bad++; $display("FAIL abort_no_done pulses=%0d want=0", dseen); end
    run_op(8'h01, 8'h02, lat, rs, rc, bb, da, ba, sa, ca);
    total++; if (rs !== 8'h03 || rc !== 1'b0 || lat !== EXP_LAT)
      begin bad++; $display("FAIL abort_restart got=%b_%h lat=%0d want=0_03 lat=%0d", rc, rs, lat, EXP_LAT); end
    // Reset and start together: reset wins.
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_vs_start_busy got=%b want=0", busy); end
    tick();
  endtask

  task automatic test_random();
    int lat, bb; logic [W-1:0] rs, sa, xa, xb; logic rc, da, ba, ca;
    logic [W:0] expv;
    for (int n = 0; n < 1000; n++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      if (n == 0) begin xa = 8'h80; xb = 8'h80; end
      expv = ref_add(xa, xb);
      run_op(xa, xb, lat, rs, rc, bb, da, ba, sa, ca);
      total++; if (rs !== expv[W-1:0]) begin bad++; $display("FAIL rand_sum a=%h b=%h got=%h want=%h", xa, xb, rs, expv[W-1:0]); end
      total++; if (rc !== expv[W]) begin bad++; $display("FAIL rand_cout a=%h b=%h got=%b want=%b", xa, xb, rc, expv[W]); end
      total++; if (lat !== EXP_LAT || da !== 1'b0) begin bad++; $display("FAIL rand_timing a=%h b=%h lat=%0d done_after=%b want lat=%0d", xa, xb, lat, da, EXP_LAT); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
